// File: rtl/mem_arb_pkg.sv
// Shared definitions for the external memory port arbiter.
// FSM state encoding, port identifiers and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 256;

  // state     | meaning
  // ST_IDLE   | waiting for a request, winner latched on exit
  // ST_BUSY   | external access in flight, waiting for ext_mem_ack
  // ST_DONE   | one-cycle completion, ack and read data to the owner
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DC = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the two refill masters.
// Build option MEM_ARB_RR_EN: defined selects round-robin on ties,
// undefined gives port 1 (data cache) fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

`ifdef MEM_ARB_RR_EN
  // On a tie the port that was not granted last wins; a lone requester always wins.
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) grant_id = ~last_grant;
    else              grant_id = req[1] ? PORT_DC : PORT_IF;
  end
`else
  logic unused_last_grant;
  assign unused_last_grant = last_grant;

  // Data cache refill/writeback always beats instruction fetch.
  always_comb begin
    grant_valid = |req;
    grant_id    = req[1] ? PORT_DC : PORT_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the external 256-bit memory port between the instruction-fetch
// refill path (port 0) and the data cache refill/writeback path (port 1).
// One transfer at a time: latch request, run the ext_mem handshake,
// then pulse a one-cycle ack with read data back to the owner.
// Tie-break policy is selected by the MEM_ARB_RR_EN macro (see mem_arb_pick).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  input  logic              p0_cs_i,
  input  logic              p0_we_i,
  output logic [DATA_W-1:0] p0_data_o,
  output logic              p0_ack_o,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_cs_i,
  input  logic              p1_we_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_ack_o,
  output logic [ADDR_W-1:0] ext_mem_addr,
  output logic [DATA_W-1:0] ext_mem_data_o,
  output logic              ext_mem_cs,
  output logic              ext_mem_we,
  input  logic [DATA_W-1:0] ext_mem_data_i,
  input  logic              ext_mem_ack
);

  logic [1:0]        state_q, state_d;
  logic              owner_q;
  logic              last_grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] p0_hold_q;
  logic [DATA_W-1:0] p1_hold_q;

  logic              grant_valid;
  logic              grant_id;

  mem_arb_pick u_pick (
    .req         ({p1_cs_i, p0_cs_i}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant_valid) state_d = ST_BUSY;
      ST_BUSY: if (ext_mem_ack) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch, read data capture and grant history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_IF;
      last_grant_q <= PORT_DC;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      rdata_q      <= '0;
      p0_hold_q    <= '0;
      p1_hold_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && grant_valid) begin
        owner_q <= grant_id;
        addr_q  <= grant_id ? p1_addr_i : p0_addr_i;
        wdata_q <= grant_id ? p1_data_i : p0_data_i;
        we_q    <= grant_id ? p1_we_i   : p0_we_i;
      end
      // Read data is captured on writes too; the owner simply ignores it.
      if (state_q == ST_BUSY && ext_mem_ack) rdata_q <= ext_mem_data_i;
      if (state_q == ST_DONE) begin
        last_grant_q <= owner_q;
        if (owner_q == PORT_IF) p0_hold_q <= rdata_q;
        else                    p1_hold_q <= rdata_q;
      end
    end
  end

  // Output decode: handshake only in BUSY, ack and fresh data only in DONE.
  always_comb begin
    ext_mem_cs     = (state_q == ST_BUSY);
    ext_mem_we     = (state_q == ST_BUSY) && we_q;
    ext_mem_addr   = addr_q;
    ext_mem_data_o = wdata_q;
    p0_ack_o       = (state_q == ST_DONE) && (owner_q == PORT_IF);
    p1_ack_o       = (state_q == ST_DONE) && (owner_q == PORT_DC);
    p0_data_o      = p0_ack_o ? rdata_q : p0_hold_q;
    p1_data_o      = p1_ack_o ? rdata_q : p1_hold_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter.
// Directed scenarios plus a randomized sequence checked against a
// transaction-level model (served-port order and expected data).
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 256;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] p0_addr_i, p1_addr_i;
  logic [DW-1:0] p0_data_i, p1_data_i;
  logic          p0_cs_i, p1_cs_i, p0_we_i, p1_we_i;
  logic [DW-1:0] p0_data_o, p1_data_o;
  logic          p0_ack_o, p1_ack_o;
  logic [AW-1:0] ext_mem_addr;
  logic [DW-1:0] ext_mem_data_o, ext_mem_data_i;
  logic          ext_mem_cs, ext_mem_we, ext_mem_ack;

  int checks = 0;
  int errors = 0;
  bit model_last;  // port served most recently, as the spec's rules track it

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_addr_i(p0_addr_i), .p0_data_i(p0_data_i), .p0_cs_i(p0_cs_i), .p0_we_i(p0_we_i),
    .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i), .p1_cs_i(p1_cs_i), .p1_we_i(p1_we_i),
    .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
    .ext_mem_addr(ext_mem_addr), .ext_mem_data_o(ext_mem_data_o),
    .ext_mem_cs(ext_mem_cs), .ext_mem_we(ext_mem_we),
    .ext_mem_data_i(ext_mem_data_i), .ext_mem_ack(ext_mem_ack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic bit tie_winner();
    if (RR) return ~model_last;
    return 1'b1;
  endfunction

  task automatic set_req(input bit port, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit we);
    if (port) begin p1_addr_i = a; p1_data_i = d; p1_we_i = we; p1_cs_i = 1'b1; end
    else      begin p0_addr_i = a; p0_data_i = d; p0_we_i = we; p0_cs_i = 1'b1; end
  endtask

  // Acts as the external memory for one transfer and checks the owner handshake.
  // Returns with the DUT in IDLE and the served port's cs dropped.
  task automatic serve(input bit port, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit we,
                       input int delay, input logic [DW-1:0] rd, output int waited);
    waited = 0;
    while (!ext_mem_cs && waited < 20) begin tick(); waited++; end
    checks++;
    if (!ext_mem_cs) begin
      errors++; $display("FAIL cs_timeout port=%0d got cs=%b want 1", port, ext_mem_cs);
      return;
    end
    checks++;
    if (ext_mem_addr !== a) begin errors++; $display("FAIL addr port=%0d got %h want %h", port, ext_mem_addr, a); end
    checks++;
    if (ext_mem_we !== we) begin errors++; $display("FAIL we port=%0d got %b want %b", port, ext_mem_we, we); end
    checks++;
    if (ext_mem_data_o !== d) begin errors++; $display("FAIL wdata port=%0d got %h want %h", port, ext_mem_data_o, d); end
    for (int i = 0; i < delay; i++) begin
      checks++;
      if (ext_mem_cs !== 1'b1 || p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0) begin
        errors++; $display("FAIL busy_hold port=%0d got cs=%b acks=%b%b want cs=1 acks=00", port, ext_mem_cs, p1_ack_o, p0_ack_o);
      end
      tick();
    end
    ext_mem_ack = 1'b1; ext_mem_data_i = rd;
    tick();
    ext_mem_ack = 1'b0; ext_mem_data_i = '0;
    checks++;
    if (ext_mem_cs !== 1'b0 || ext_mem_we !== 1'b0) begin
      errors++; $display("FAIL done_cs port=%0d got cs=%b we=%b want 0 0", port, ext_mem_cs, ext_mem_we);
    end
    checks++;
    if ({p1_ack_o, p0_ack_o} !== (port ? 2'b10 : 2'b01)) begin
      errors++; $display("FAIL ack port=%0d got %b%b want %b", port, p1_ack_o, p0_ack_o, port ? 2'b10 : 2'b01);
    end
    checks++;
    if ((port ? p1_data_o : p0_data_o) !== rd) begin
      errors++; $display("FAIL rdata port=%0d got %h want %h", port, port ? p1_data_o : p0_data_o, rd);
    end
    if (port) p1_cs_i = 1'b0; else p0_cs_i = 1'b0;
    model_last = port;
    tick();
    checks++;
    if (p0_ack_o !== 1'b0 || p1_ack_o !== 1'b0 || (port ? p1_data_o : p0_data_o) !== rd) begin
      errors++; $display("FAIL after_done port=%0d got acks=%b%b data=%h want acks=00 data=%h",
                         port, p1_ack_o, p0_ack_o, port ? p1_data_o : p0_data_o, rd);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    p0_cs_i = 0; p1_cs_i = 0; p0_we_i = 0; p1_we_i = 0;
    p0_addr_i = '0; p1_addr_i = '0; p0_data_i = '0; p1_data_i = '0;
    ext_mem_ack = 0; ext_mem_data_i = '0;
    tick(); tick();
    rst = 1'b0;
    model_last = 1'b1;
    checks++;
    if (ext_mem_cs !== 0 || ext_mem_we !== 0 || ext_mem_addr !== '0 || ext_mem_data_o !== '0 ||
        p0_ack_o !== 0 || p1_ack_o !== 0 || p0_data_o !== '0 || p1_data_o !== '0) begin
      errors++; $display("FAIL reset_outputs got cs=%b we=%b addr=%h acks=%b%b want all zero",
                         ext_mem_cs, ext_mem_we, ext_mem_addr, p1_ack_o, p0_ack_o);
    end
  endtask

  task automatic test_read();
    int w;
    logic [DW-1:0] rd = rnd_line();
    set_req(1'b0, 32'h100, '0, 1'b0);
    serve(1'b0, 32'h100, '0, 1'b0, 3, rd, w);
    checks++;
    if (w !== 1) begin errors++; $display("FAIL read_latency got %0d want 1", w); end
  endtask

  task automatic test_write();
    int w;
    logic [DW-1:0] d = {8{32'hDEADBEEF}};
    set_req(1'b1, 32'h200, d, 1'b1);
    serve(1'b1, 32'h200, d, 1'b1, 2, rnd_line(), w);
  endtask

  task automatic test_tie();
    int w;
    bit first;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        set_req(1'b0, 32'h340, '0, 1'b0);
        serve(1'b0, 32'h340, '0, 1'b0, 0, rnd_line(), w);
      end
      first = tie_winner();
      checks++;
      if (k == 0 && first !== (RR ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL tie_first_after_reset got %0d want %0d", first, RR ? 0 : 1);
      end
      set_req(1'b0, 32'h300 + k, {8{32'h0000_0A0A}}, 1'b0);
      set_req(1'b1, 32'h380 + k, {8{32'h0000_0B0B}}, 1'b1);
      serve(first, first ? 32'h380 + k : 32'h300 + k, first ? {8{32'h0000_0B0B}} : {8{32'h0000_0A0A}},
            first, 1, rnd_line(), w);
      serve(~first, first ? 32'h300 + k : 32'h380 + k, first ? {8{32'h0000_0A0A}} : {8{32'h0000_0B0B}},
            ~first, 0, rnd_line(), w);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL tie_second_wait got %0d want 1", w); end
    end
  endtask

  task automatic test_overlap();
    int w;
    logic [DW-1:0] rd = rnd_line();
    set_req(1'b1, 32'h400, rnd_line(), 1'b0);
    tick(); tick();
    set_req(1'b0, 32'h480, '0, 1'b0);
    serve(1'b1, 32'h400, p1_data_i, 1'b0, 3, rd, w);
    checks++;
    if (ext_mem_cs !== 1'b0) begin errors++; $display("FAIL overlap_idle_cs got %b want 0", ext_mem_cs); end
    serve(1'b0, 32'h480, '0, 1'b0, 1, rnd_line(), w);
    checks++;
    if (w !== 1) begin errors++; $display("FAIL overlap_grant_wait got %0d want 1", w); end
  endtask

  task automatic test_rst_busy();
    int w;
    set_req(1'b0, 32'h500, '0, 1'b0);
    tick(); tick();
    checks++;
    if (ext_mem_cs !== 1'b1) begin errors++; $display("FAIL rst_pre_cs got %b want 1", ext_mem_cs); end
    rst = 1'b1; p0_cs_i = 1'b0;
    tick();
    rst = 1'b0; model_last = 1'b1;
    checks++;
    if (ext_mem_cs !== 1'b0 || p0_ack_o !== 0 || p1_ack_o !== 0 || p0_data_o !== '0) begin
      errors++; $display("FAIL rst_busy got cs=%b acks=%b%b want cs=0 acks=00", ext_mem_cs, p1_ack_o, p0_ack_o);
    end
    for (int i = 0; i < 4; i++) begin
      ext_mem_ack = (i == 1);
      tick();
      checks++;
      if (p0_ack_o !== 0 || p1_ack_o !== 0 || ext_mem_cs !== 0) begin
        errors++; $display("FAIL rst_quiet got cs=%b acks=%b%b want 0 00", ext_mem_cs, p1_ack_o, p0_ack_o);
      end
    end
    ext_mem_ack = 1'b0;
    set_req(1'b1, 32'h540, rnd_line(), 1'b1);
    serve(1'b1, 32'h540, p1_data_i, 1'b1, 2, rnd_line(), w);
  endtask

  task automatic test_idle_ack();
    ext_mem_ack = 1'b1; ext_mem_data_i = rnd_line();
    tick();
    ext_mem_ack = 1'b0; ext_mem_data_i = '0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ext_mem_cs !== 0 || p0_ack_o !== 0 || p1_ack_o !== 0) begin
        errors++; $display("FAIL idle_ack got cs=%b acks=%b%b want 0 00", ext_mem_cs, p1_ack_o, p0_ack_o);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int w;
    logic [AW-1:0] a [2];
    logic [DW-1:0] d [2];
    bit            we [2];
    bit            order [$];
    int            mask;
    for (int it = 0; it < 40; it++) begin
      mask = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        a[p] = $urandom & 32'hFFFF_FFE0;
        d[p] = rnd_line();
        we[p] = $urandom_range(0, 1);
        if (mask[p]) set_req(p[0], a[p], d[p], we[p]);
      end
      order.delete();
      if (mask == 3) begin
        order.push_back(tie_winner());
        order.push_back(~tie_winner());
      end else begin
        order.push_back(mask == 2);
      end
      while (order.size() > 0) begin
        bit p = order.pop_front();
        serve(p, a[p], d[p], we[p], $urandom_range(0, 4), rnd_line(), w);
      end
      if ($urandom_range(0, 3) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_overlap();
    test_rst_busy();
    test_idle_ack();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
